pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
//
// Fetch-to-decode pipeline register carrying a {pc, instruction} pair with
// valid/ready handshaking on both sides. With SKID=1 it is a two-entry skid
// buffer whose in_ready is a flop, so the upstream ready path is cut from
// out_ready. With SKID=0 it is a single register whose in_ready passes
// out_ready through combinationally.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous discard of every held entry (wins over transfers)
//   in_valid   in   upstream entry valid
//   in_ready   out  block can accept an entry this cycle
//   in_pc      in   upstream program counter        [PC_W]
//   in_data    in   upstream instruction            [DATA_W]
//   out_valid  out  head entry valid to decode
//   out_ready  in   decode accepts the head entry
//   out_pc     out  head program counter, 0 when idle
//   out_data   out  head instruction, NOP_VAL when idle
//   occupancy  out  number of held entries (0..2)
//
// State table
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_EMPTY | nothing held; outputs show a bubble
//   ST_ONE   | head entry held and presented to decode
//   ST_TWO   | head plus skid entry held; upstream back-pressured (SKID=1 only)
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned       PC_W    = 16,
    parameter int unsigned       DATA_W  = 16,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter bit                SKID    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic                in_ready_q,  in_ready_d;
    logic [PC_W-1:0]     head_pc_q,   head_pc_d;
    logic [DATA_W-1:0]   head_data_q, head_data_d;
    logic [PC_W-1:0]     skid_pc_q,   skid_pc_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid  & in_ready;
    assign out_fire = out_valid & out_ready;

    // ------------------------------------------------------------------------
    // State and payload registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            head_pc_q   <= '0;
            head_data_q <= NOP_VAL;
            skid_pc_q   <= '0;
            skid_data_q <= NOP_VAL;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            head_pc_q   <= head_pc_d;
            head_data_q <= head_data_d;
            skid_pc_q   <= skid_pc_d;
            skid_data_q <= skid_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and payload capture
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        head_pc_d   = head_pc_q;
        head_data_d = head_data_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Payload registers are left alone; out_valid=0 masks them.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_ONE;
                        head_pc_d   = in_pc;
                        head_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    unique case ({in_fire, out_fire})
                        2'b10: begin
                            // Only reachable with SKID=1: in SKID=0 a held
                            // head blocks in_ready unless out_ready is high.
                            if (SKID) begin
                                state_d     = ST_TWO;
                                skid_pc_d   = in_pc;
                                skid_data_d = in_data;
                            end
                        end
                        2'b01: begin
                            state_d = ST_EMPTY;
                        end
                        2'b11: begin
                            head_pc_d   = in_pc;
                            head_data_d = in_data;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_TWO: begin
                    // in_ready is low here, so only the head can move.
                    if (out_fire) begin
                        state_d     = ST_ONE;
                        head_pc_d   = skid_pc_q;
                        head_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        // Registered ready: low exactly when the next state is full. Also
        // serves as the "out of reset" qualifier for the SKID=0 path.
        in_ready_d = (state_d != ST_TWO);
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        out_pc    = '0;
        out_data  = NOP_VAL;
        if (out_valid) begin
            out_pc   = head_pc_q;
            out_data = head_data_q;
        end

        if (SKID) begin
            in_ready = in_ready_q;
        end else begin
            in_ready = in_ready_q & (~out_valid | out_ready);
        end

        occupancy = state_q;
    end

endmodule
